hdmi_packet_scheduler: RTL and testbench

Arbiter that shares the single per-line HDMI data-island slot among four packet sources: Audio Clock Regeneration (ACR), audio samples, AVI InfoFrame and Audio InfoFrame. It sits in the `clk_pixel` domain between the video timing counters (`cx`, `cy`) and the packet assembler/TMDS path. Each horizontal blanking interval it picks at most one packet and issues a start pulse, type and audio sample count to the assembler.

---
 rtl/hdmi_pkg.sv | 20 ++
 rtl/hdmi_packet_scheduler.sv | 138 +++++++++++++
 tb/tb_hdmi_packet_scheduler.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hdmi_pkg.sv
// Shared definitions for the HDMI data-island packet path.
package hdmi_pkg;

  typedef enum logic [2:0] {
    PKT_NULL  = 3'd0,
    PKT_ACR   = 3'd1,
    PKT_AUDIO = 3'd2,
    PKT_AVI   = 3'd3,
    PKT_AINFO = 3'd4
  } packet_type_t;

  localparam int PACKET_CLKS_DEFAULT    = 32;
  localparam int MAX_SAMPLES_PER_PACKET = 4;

  // Samples an audio packet can carry given the current backlog.
  function automatic logic [3:0] take_samples(input logic [3:0] pend);
    return (pend > 4'(MAX_SAMPLES_PER_PACKET)) ? 4'(MAX_SAMPLES_PER_PACKET) : pend;
  endfunction

endpackage

// File: rtl/hdmi_packet_scheduler.sv
// Per-line data-island arbiter: picks at most one of ACR / audio / AVI / audio
// InfoFrame at the blanking slot and drives the packet assembler handshake.
module hdmi_packet_scheduler
  import hdmi_pkg::*;
#(
  parameter int                 BIT_WIDTH   = 10,
  parameter logic [BIT_WIDTH-1:0] SLOT_X    = 10'd16,
  parameter int                 ACR_LINES   = 16,
  parameter int                 PACKET_CLKS = PACKET_CLKS_DEFAULT,
  parameter int                 MAX_PENDING = 15
) (
  input  logic                 clk_pixel,
  input  logic                 reset,
  input  logic [BIT_WIDTH-1:0] cx,
  input  logic [BIT_WIDTH-1:0] cy,
  input  logic                 sample_tick,
  output logic                 pkt_start,
  output logic [2:0]           pkt_type,
  output logic [2:0]           pkt_samples,
  output logic                 pkt_busy,
  output logic                 overflow
);

  localparam int CNT_W  = (PACKET_CLKS > 2) ? $clog2(PACKET_CLKS) : 1;
  localparam int SLOT_W = (ACR_LINES > 2) ? $clog2(ACR_LINES) : 1;

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   busy_cnt_q, busy_cnt_d;
  logic [SLOT_W-1:0]  slot_cnt_q, slot_cnt_d;
  logic               acr_pend_q, acr_pend_d;
  logic               avi_pend_q, avi_pend_d;
  logic               ainfo_pend_q, ainfo_pend_d;
  logic [3:0]         pending_q, pending_d;
  logic               overflow_q, overflow_d;
  logic               pkt_start_q, pkt_start_d;
  packet_type_t       pkt_type_q, pkt_type_d;
  logic [2:0]         pkt_samples_q, pkt_samples_d;

  logic               frame_start, slot, wrap;
  packet_type_t       grant;
  logic [3:0]         taken, pend_sub;

  assign frame_start = (cx == '0) && (cy == '0);
  assign slot        = (cx == SLOT_X);
  assign wrap        = slot && (slot_cnt_q == SLOT_W'(ACR_LINES - 1));

  always_comb begin
    grant         = PKT_NULL;
    taken         = '0;
    state_d       = state_q;
    busy_cnt_d    = busy_cnt_q;
    slot_cnt_d    = slot_cnt_q;
    pending_d     = pending_q;
    overflow_d    = overflow_q;
    pkt_start_d   = 1'b0;
    pkt_type_d    = pkt_type_q;
    pkt_samples_d = pkt_samples_q;

    // A wrapping slot makes ACR due in the very slot that wrapped.
    if (slot && state_q == S_IDLE) begin
      if (acr_pend_q || wrap)      grant = PKT_ACR;
      else if (pending_q != '0) begin
        grant = PKT_AUDIO;
        taken = take_samples(pending_q);
      end
      else if (avi_pend_q)         grant = PKT_AVI;
      else if (ainfo_pend_q)       grant = PKT_AINFO;
    end

    if (slot) slot_cnt_d = wrap ? '0 : slot_cnt_q + 1'b1;

    acr_pend_d   = (acr_pend_q   && grant != PKT_ACR)   || wrap;
    avi_pend_d   = (avi_pend_q   && grant != PKT_AVI)   || frame_start;
    ainfo_pend_d = (ainfo_pend_q && grant != PKT_AINFO) || frame_start;

    // Grant is subtracted first so a tick arriving with the grant is kept.
    pend_sub  = pending_q - taken;
    pending_d = pend_sub;
    if (sample_tick) begin
      if (pend_sub == 4'(MAX_PENDING)) overflow_d = 1'b1;
      else                             pending_d  = pend_sub + 4'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (grant != PKT_NULL) begin
          state_d       = S_SEND;
          busy_cnt_d    = CNT_W'(PACKET_CLKS - 1);
          pkt_start_d   = 1'b1;
          pkt_type_d    = grant;
          pkt_samples_d = (grant == PKT_AUDIO) ? taken[2:0] : 3'd0;
        end
      end
      S_SEND: begin
        if (busy_cnt_q == '0) state_d    = S_IDLE;
        else                  busy_cnt_d = busy_cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_q       <= S_IDLE;
      busy_cnt_q    <= '0;
      slot_cnt_q    <= '0;
      acr_pend_q    <= 1'b0;
      avi_pend_q    <= 1'b0;
      ainfo_pend_q  <= 1'b0;
      pending_q     <= '0;
      overflow_q    <= 1'b0;
      pkt_start_q   <= 1'b0;
      pkt_type_q    <= PKT_NULL;
      pkt_samples_q <= '0;
    end else begin
      state_q       <= state_d;
      busy_cnt_q    <= busy_cnt_d;
      slot_cnt_q    <= slot_cnt_d;
      acr_pend_q    <= acr_pend_d;
      avi_pend_q    <= avi_pend_d;
      ainfo_pend_q  <= ainfo_pend_d;
      pending_q     <= pending_d;
      overflow_q    <= overflow_d;
      pkt_start_q   <= pkt_start_d;
      pkt_type_q    <= pkt_type_d;
      pkt_samples_q <= pkt_samples_d;
    end
  end

  assign pkt_start   = pkt_start_q;
  assign pkt_type    = pkt_type_q;
  assign pkt_samples = pkt_samples_q;
  assign pkt_busy    = (state_q == S_SEND);
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_hdmi_packet_scheduler.sv
// Bench for hdmi_packet_scheduler: directed scenarios then randomized frames,
// all compared cycle by cycle against a behavioural scheduler model.
module tb_hdmi_packet_scheduler;

  localparam int SLOT      = 16;
  localparam int ACR_N     = 16;
  localparam int PKT_CLKS  = 32;
  localparam int MAXP      = 15;
  localparam int IDLE_X    = 100;
  localparam int T_NULL = 0, T_ACR = 1, T_AUDIO = 2, T_AVI = 3, T_AINFO = 4;

  logic       clk_pixel = 1'b0;
  logic       reset     = 1'b1;
  logic [9:0] cx        = '0;
  logic [9:0] cy        = '0;
  logic       sample_tick = 1'b0;
  logic       pkt_start;
  logic [2:0] pkt_type;
  logic [2:0] pkt_samples;
  logic       pkt_busy;
  logic       overflow;

  hdmi_packet_scheduler dut (
    .clk_pixel   (clk_pixel),
    .reset       (reset),
    .cx          (cx),
    .cy          (cy),
    .sample_tick (sample_tick),
    .pkt_start   (pkt_start),
    .pkt_type    (pkt_type),
    .pkt_samples (pkt_samples),
    .pkt_busy    (pkt_busy),
    .overflow    (overflow)
  );

  always #5 clk_pixel = ~clk_pixel;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: plain integers describing the scheduler's bookkeeping.
  int m_pending, m_slots, m_busy_left;
  bit m_acr, m_avi, m_ain, m_ovf;
  int e_start, e_type, e_samples, e_busy, e_ovf;
  int line_grant [0:ACR_N-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model(input int x, input int y, input bit tk, input bit r);
    bit busy_now, wrap, frame, slot;
    int g, take;
    if (r) begin
      m_pending = 0; m_slots = 0; m_busy_left = 0;
      m_acr = 0; m_avi = 0; m_ain = 0; m_ovf = 0;
      e_start = 0; e_type = T_NULL; e_samples = 0; e_busy = 0; e_ovf = 0;
      return;
    end
    busy_now = (m_busy_left > 0);
    frame = (x == 0) && (y == 0);
    slot  = (x == SLOT);
    wrap  = 0;
    g = T_NULL;
    take = 0;
    if (slot) begin
      m_slots++;
      if (m_slots == ACR_N) begin
        m_slots = 0;
        wrap = 1;
      end
    end
    if (slot && !busy_now) begin
      if (m_acr || wrap)       g = T_ACR;
      else if (m_pending > 0) begin
        g = T_AUDIO;
        take = (m_pending < 4) ? m_pending : 4;
      end
      else if (m_avi)          g = T_AVI;
      else if (m_ain)          g = T_AINFO;
    end
    if (g == T_ACR)   m_acr = 0;
    if (g == T_AVI)   m_avi = 0;
    if (g == T_AINFO) m_ain = 0;
    if (wrap)  m_acr = 1;
    if (frame) begin m_avi = 1; m_ain = 1; end
    m_pending -= take;
    if (tk) begin
      if (m_pending == MAXP) m_ovf = 1;
      else                   m_pending++;
    end
    e_start = (g != T_NULL);
    if (g != T_NULL) begin
      e_type = g;
      e_samples = take;
      m_busy_left = PKT_CLKS;
    end else if (m_busy_left > 0) begin
      m_busy_left--;
    end
    e_busy = (m_busy_left > 0);
    e_ovf  = m_ovf;
  endtask

  task automatic step(input int x, input int y, input bit tk, input bit r);
    cx = 10'(x);
    cy = 10'(y);
    sample_tick = tk;
    reset = r;
    @(posedge clk_pixel);
    model(x, y, tk, r);
    #1;
    check("pkt_start",   {31'd0, pkt_start},  e_start);
    check("pkt_type",    {29'd0, pkt_type},   e_type);
    check("pkt_samples", {29'd0, pkt_samples}, e_samples);
    check("pkt_busy",    {31'd0, pkt_busy},   e_busy);
    check("overflow",    {31'd0, overflow},   e_ovf);
  endtask

  task automatic run_to_slot(input int y, input bit tick_at_slot);
    for (int x = 0; x <= SLOT; x++) step(x, y, (x == SLOT) && tick_at_slot, 1'b0);
  endtask

  task automatic finish_line(input int len, input int y);
    for (int x = SLOT + 1; x < len; x++) step(x, y, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n, input bit tk);
    for (int i = 0; i < n; i++) step(IDLE_X, 5, tk, 1'b0);
  endtask

  task automatic do_reset();
    step(IDLE_X, 5, 1'b0, 1'b1);
    step(IDLE_X, 5, 1'b0, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;

    // Reset values
    do_reset();
    check("rst_start",   {31'd0, pkt_start}, 0);
    check("rst_type",    {29'd0, pkt_type}, T_NULL);
    check("rst_samples", {29'd0, pkt_samples}, 0);
    check("rst_busy",    {31'd0, pkt_busy}, 0);
    check("rst_ovf",     {31'd0, overflow}, 0);
    check("rst_pending", {28'd0, dut.pending_q}, 0);

    // First frame without audio
    for (int y = 0; y < ACR_N; y++) begin
      run_to_slot(y, 1'b0);
      line_grant[y] = pkt_start ? int'(pkt_type) : -1;
      finish_line(40, y);
    end
    check("frame_l0_avi",    line_grant[0], T_AVI);
    check("frame_l1_ainfo",  line_grant[1], T_AINFO);
    check("frame_l15_acr",   line_grant[15], T_ACR);
    for (int y = 2; y < 15; y++) check("frame_quiet_line", line_grant[y], -1);

    // Six samples drained four then two
    do_reset();
    idle(6, 1'b1);
    run_to_slot(5, 1'b0);
    check("aud6_type",    {29'd0, pkt_type}, T_AUDIO);
    check("aud6_samples", {29'd0, pkt_samples}, 4);
    check("aud6_pending", {28'd0, dut.pending_q}, 2);
    finish_line(40, 5);
    run_to_slot(6, 1'b0);
    check("aud2_samples", {29'd0, pkt_samples}, 2);
    check("aud2_pending", {28'd0, dut.pending_q}, 0);
    finish_line(40, 6);

    // Tick on the grant edge
    idle(3, 1'b1);
    run_to_slot(7, 1'b1);
    check("coinc_samples", {29'd0, pkt_samples}, 3);
    check("coinc_pending", {28'd0, dut.pending_q}, 1);
    finish_line(40, 7);
    run_to_slot(8, 1'b0);
    check("coinc_drain", {29'd0, pkt_samples}, 1);
    finish_line(40, 8);

    // Saturation
    idle(16, 1'b1);
    check("sat_pending",  {28'd0, dut.pending_q}, MAXP);
    check("sat_overflow", {31'd0, overflow}, 1);
    idle(1, 1'b1);
    check("sat_hold",     {28'd0, dut.pending_q}, MAXP);
    check("sat_sticky",   {31'd0, overflow}, 1);
    do_reset();
    check("sat_cleared",  {31'd0, overflow}, 0);

    // ACR beats pending audio at the wrapping slot
    for (int y = 0; y < ACR_N - 1; y++) begin
      run_to_slot(y + 2, 1'b0);
      check("acr_quiet", {31'd0, pkt_start}, 0);
      finish_line(40, y + 2);
    end
    idle(2, 1'b1);
    run_to_slot(20, 1'b0);
    check("acr_start",   {31'd0, pkt_start}, 1);
    check("acr_type",    {29'd0, pkt_type}, T_ACR);
    check("acr_samples", {29'd0, pkt_samples}, 0);
    check("acr_audio_waits", {28'd0, dut.pending_q}, 2);
    cnt = pkt_busy ? 1 : 0;
    while (pkt_busy && cnt < 100) begin
      step(IDLE_X, 20, 1'b0, 1'b0);
      if (pkt_busy) cnt++;
    end
    check("acr_busy_len", cnt, PKT_CLKS);

    // Reset in the middle of a packet
    do_reset();
    idle(3, 1'b1);
    run_to_slot(5, 1'b0);
    check("abort_started", {31'd0, pkt_start}, 1);
    idle(10, 1'b0);
    step(IDLE_X, 5, 1'b0, 1'b1);
    check("abort_busy",    {31'd0, pkt_busy}, 0);
    check("abort_type",    {29'd0, pkt_type}, T_NULL);
    check("abort_pending", {28'd0, dut.pending_q}, 0);
    run_to_slot(6, 1'b0);
    check("abort_no_start", {31'd0, pkt_start}, 0);
    finish_line(40, 6);

    // Randomized frames, including short lines that collide with busy
    do_reset();
    for (int f = 0; f < 4; f++) begin
      int nl;
      nl = int'($urandom_range(6, 20));
      for (int y = 0; y < nl; y++) begin
        int len;
        len = int'($urandom_range(20, 60));
        for (int x = 0; x < len; x++) step(x, y, ($urandom_range(0, 7) == 0), 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
